// File: rtl/seq_alu.sv
// Registered ALU with a multi-cycle unsigned shift-add multiplier.
// A start/busy/done handshake wraps both the single-cycle ops and the WIDTH-cycle MUL.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             c_out,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] op_res;
    logic             op_c;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;

    // Single-cycle operations
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        case (alu_op)
            OP_AND: op_res = a & b;
            OP_OR:  op_res = a | b;
            OP_XOR: op_res = a ^ b;
            OP_ADD: {op_c, op_res} = {1'b0, a} + {1'b0, b};
            OP_SUB: {op_c, op_res} = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
            OP_SLT: op_res = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: op_res = ~(a | b);
            default: op_res = '0;
        endcase
    end

    // One shift-add iteration; the add carry lands in the MSB of hi after the shift
    always_comb begin
        mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            c_out     <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (alu_op == OP_MUL) begin
                            mcand <= a;
                            lo    <= b;
                            hi    <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= MUL;
                        end else begin
                            result    <= op_res;
                            result_hi <= '0;
                            c_out     <= op_c;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    hi  <= mul_hi_nxt;
                    lo  <= mul_lo_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        result    <= mul_lo_nxt;
                        result_hi <= mul_hi_nxt;
                        c_out     <= |mul_hi_nxt;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: 32-bit and 8-bit instances checked every cycle against an
// operation-level model, plus hand-computed literal expectations.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [2];
    logic        st_v  [2];
    logic [2:0]  op_v  [2];
    logic [31:0] a_v   [2];
    logic [31:0] b_v   [2];

    logic [31:0] dres  [2];
    logic [31:0] dhi   [2];
    logic        dc    [2];
    logic        dbusy [2];
    logic        ddone [2];

    logic [7:0]  r8, h8;
    logic [7:0]  a8, b8;

    int checks = 0;
    int errors = 0;

    assign a8 = a_v[1][7:0];
    assign b8 = b_v[1][7:0];

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst_v[0]), .start(st_v[0]), .alu_op(op_v[0]),
        .a(a_v[0]), .b(b_v[0]), .busy(dbusy[0]), .done(ddone[0]),
        .c_out(dc[0]), .result(dres[0]), .result_hi(dhi[0])
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_v[1]), .start(st_v[1]), .alu_op(op_v[1]),
        .a(a8), .b(b8), .busy(dbusy[1]), .done(ddone[1]),
        .c_out(dc[1]), .result(r8), .result_hi(h8)
    );

    assign dres[1] = 32'(r8);
    assign dhi[1]  = 32'(h8);

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        c;
    } out_t;

    // Operation-level reference: whole result from plain 64-bit arithmetic
    function automatic out_t calc(input logic [2:0] op, input logic [31:0] ai,
                                  input logic [31:0] bi, input int w);
        longint unsigned mask, x, y, s;
        longint sx, sy;
        out_t o;
        mask = (64'd1 << w) - 64'd1;
        x = 64'(ai) & mask;
        y = 64'(bi) & mask;
        o = '0;
        case (op)
            3'd0: o.res = 32'(x & y);
            3'd1: o.res = 32'(x | y);
            3'd2: o.res = 32'(x ^ y);
            3'd7: o.res = 32'(~(x | y) & mask);
            3'd4: begin
                s = x + y;
                o.res = 32'(s & mask);
                o.c = s[w];
            end
            3'd5: begin
                o.res = 32'((x - y) & mask);
                o.c = (x >= y);
            end
            3'd6: begin
                sx = x[w-1] ? $signed(x) - $signed(64'd1 << w) : $signed(x);
                sy = y[w-1] ? $signed(y) - $signed(64'd1 << w) : $signed(y);
                o.res = 32'(sx < sy);
            end
            default: begin
                s = x * y;
                o.res = 32'(s & mask);
                o.hi = 32'((s >> w) & mask);
                o.c = (o.hi != 32'd0);
            end
        endcase
        return o;
    endfunction

    // Model: 0 = idle, 1 = multiply in flight (rem edges left), 2 = done cycle
    int   m_mode  [2];
    int   m_rem   [2];
    out_t m_out   [2];
    out_t m_pend  [2];
    bit   m_valid [2];

    task automatic model_step(input int i, input int w);
        if (rst_v[i] === 1'b1) begin
            m_mode[i]  = 0;
            m_rem[i]   = 0;
            m_out[i]   = '0;
            m_valid[i] = 1'b1;
        end else if (m_mode[i] == 1) begin
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) begin
                m_out[i]  = m_pend[i];
                m_mode[i] = 2;
            end
        end else if (st_v[i] === 1'b1) begin
            if (op_v[i] == 3'd3) begin
                m_pend[i] = calc(op_v[i], a_v[i], b_v[i], w);
                m_rem[i]  = w;
                m_mode[i] = 1;
            end else begin
                m_out[i]  = calc(op_v[i], a_v[i], b_v[i], w);
                m_mode[i] = 2;
            end
        end else begin
            m_mode[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 32);
        model_step(1, 8);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
                chk(i == 0 ? "w32_result" : "w8_result", 64'(dres[i]), 64'(m_out[i].res));
                chk(i == 0 ? "w32_hi" : "w8_hi", 64'(dhi[i]), 64'(m_out[i].hi));
                chk(i == 0 ? "w32_c" : "w8_c", 64'(dc[i]), 64'(m_out[i].c));
                chk(i == 0 ? "w32_busy" : "w8_busy", 64'(dbusy[i]), 64'(m_mode[i] == 1));
                chk(i == 0 ? "w32_done" : "w8_done", 64'(ddone[i]), 64'(m_mode[i] == 2));
                chk(i == 0 ? "w32_busy_done_excl" : "w8_busy_done_excl",
                    64'(dbusy[i] & ddone[i]), 64'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_in(input int i, input logic st, input logic [2:0] op,
                          input logic [31:0] av, input logic [31:0] bv);
        st_v[i] = st;
        op_v[i] = op;
        a_v[i]  = av;
        b_v[i]  = bv;
    endtask

    task automatic wait_done(input int i, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ddone[i] !== 1'b1 && n < bound);
        chk("done_seen", 64'(ddone[i]), 64'd1);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF;
            1: return 32'($urandom_range(0, 15));
            2: return 32'h8000_0000 | 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1;
            set_in(i, 1'b0, 3'd0, 32'd0, 32'd0);
        end
        step();
        step();
        rst_v[0] = 1'b0;
        chk("reset_result", 64'(dres[0]), 64'd0);
        chk("reset_busy", 64'(dbusy[0]), 64'd0);
        chk("reset_done", 64'(ddone[0]), 64'd0);

        // NOR then back-to-back NOR and OR with start held high
        set_in(0, 1'b1, 3'b111, 32'h0000_0014, 32'h0000_0013);
        step();
        chk("nor1_result", 64'(dres[0]), 64'hFFFF_FFE8);
        chk("nor1_c", 64'(dc[0]), 64'd0);
        chk("nor1_done", 64'(ddone[0]), 64'd1);
        set_in(0, 1'b1, 3'b111, 32'h0000_0A40, 32'h0000_0F13);
        step();
        chk("nor2_result", 64'(dres[0]), 64'hFFFF_F0AC);
        chk("nor2_done", 64'(ddone[0]), 64'd1);
        set_in(0, 1'b1, 3'b001, 32'h0000_0A40, 32'h0000_0F13);
        step();
        chk("or_result", 64'(dres[0]), 64'h0000_0F53);
        st_v[0] = 1'b0;
        step();
        chk("done_one_cycle", 64'(ddone[0]), 64'd0);
        chk("hold_result", 64'(dres[0]), 64'h0000_0F53);

        set_in(0, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        chk("add_wrap_result", 64'(dres[0]), 64'd0);
        chk("add_wrap_c", 64'(dc[0]), 64'd1);
        set_in(0, 1'b1, 3'b101, 32'd3, 32'd5);
        step();
        chk("sub_result", 64'(dres[0]), 64'hFFFF_FFFE);
        chk("sub_c", 64'(dc[0]), 64'd0);
        set_in(0, 1'b1, 3'b110, 32'h8000_0000, 32'd1);
        step();
        chk("slt_result", 64'(dres[0]), 64'd1);
        st_v[0] = 1'b0;
        step();

        // Full-width multiply: latency and product
        set_in(0, 1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        st_v[0] = 1'b0;
        chk("mul_busy", 64'(dbusy[0]), 64'd1);
        wait_done(0, 40, n);
        chk("mul_latency", 64'(n), 64'd32);
        chk("mul_result", 64'(dres[0]), 64'h0000_0001);
        chk("mul_hi", 64'(dhi[0]), 64'hFFFF_FFFE);
        chk("mul_c", 64'(dc[0]), 64'd1);
        chk("mul_busy_end", 64'(dbusy[0]), 64'd0);

        // Back-to-back ADD accepted in the DONE cycle
        set_in(0, 1'b1, 3'b100, 32'd5, 32'd9);
        step();
        chk("b2b_add_result", 64'(dres[0]), 64'd14);
        chk("b2b_add_hi", 64'(dhi[0]), 64'd0);
        chk("b2b_add_done", 64'(ddone[0]), 64'd1);
        st_v[0] = 1'b0;
        step();

        // MUL 6x7 with start pulses and operand churn while iterating
        set_in(0, 1'b1, 3'b011, 32'd6, 32'd7);
        step();
        n = 0;
        do begin
            set_in(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            step();
            n++;
        end while (ddone[0] !== 1'b1 && n < 40);
        chk("mul67_done", 64'(ddone[0]), 64'd1);
        chk("mul67_latency", 64'(n), 64'd32);
        chk("mul67_result", 64'(dres[0]), 64'd42);
        chk("mul67_hi", 64'(dhi[0]), 64'd0);
        chk("mul67_c", 64'(dc[0]), 64'd0);
        st_v[0] = 1'b0;
        step();
        step();

        // Reset landing on iteration 10 of a multiply
        set_in(0, 1'b1, 3'b011, 32'd123, 32'd456);
        step();
        st_v[0] = 1'b0;
        repeat (9) step();
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        chk("midrst_busy", 64'(dbusy[0]), 64'd0);
        chk("midrst_done", 64'(ddone[0]), 64'd0);
        chk("midrst_result", 64'(dres[0]), 64'd0);
        chk("midrst_hi", 64'(dhi[0]), 64'd0);
        chk("midrst_c", 64'(dc[0]), 64'd0);
        set_in(0, 1'b1, 3'b011, 32'd6, 32'd7);
        step();
        st_v[0] = 1'b0;
        wait_done(0, 40, n);
        chk("postrst_mul_result", 64'(dres[0]), 64'd42);

        // 8-bit instance
        rst_v[1] = 1'b0;
        set_in(1, 1'b1, 3'b011, 32'h0000_00FF, 32'h0000_00FF);
        step();
        st_v[1] = 1'b0;
        wait_done(1, 16, n);
        chk("w8_mul_latency", 64'(n), 64'd8);
        chk("w8_mul_result", 64'(dres[1]), 64'h01);
        chk("w8_mul_hi", 64'(dhi[1]), 64'hFE);
        chk("w8_mul_c", 64'(dc[1]), 64'd1);
        set_in(1, 1'b1, 3'b100, 32'h0000_0080, 32'h0000_0080);
        step();
        chk("w8_add_result", 64'(dres[1]), 64'h00);
        chk("w8_add_c", 64'(dc[1]), 64'd1);
        st_v[1] = 1'b0;
        step();

        // Randomized traffic on both instances, occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                rst_v[i] = ($urandom_range(0, 99) == 0);
                set_in(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       rnd_operand(), rnd_operand());
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b0;
            st_v[i]  = 1'b0;
        end
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU that extends the 32-bit combinational ALU to a configurable width. It adds a multi-cycle unsigned shift-add multiply, a start/busy/done handshake and registered outputs. It sits between the register-file read stage and write-back in the multi-cycle datapath. It keeps the same 3-bit operation encoding family, with NOR at 3'b111.

## Interface
- WIDTH, 32, operand/result width in bits (≥4)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  request; sampled only in IDLE or DONE
- alu_op  in  3  operation select (see Operation)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  high while a MUL is iterating
- done  out  1  one-cycle pulse: result/result_hi/c_out updated
- c_out  out  1  carry/flag for completed op
- result  out  WIDTH  result (MUL: low half)
- result_hi  out  WIDTH  MUL high half; 0 for all other ops

## Operation
- alu_op: 000 AND, 001 OR, 010 XOR, 011 MUL (unsigned), 100 ADD, 101 SUB, 110 SLT (signed), 111 NOR.
- c_out rules:
  - ADD: carry out of bit WIDTH-1.
  - SUB: carry of a + ~b + 1 (1 ⇔ a ≥ b unsigned).
  - MUL: 1 ⇔ result_hi ≠ 0.
  - AND/OR/XOR/NOR/SLT: 0.
- SLT: result = {WIDTH-1 zeros, (a < b signed)}.
- All arithmetic is modulo 2^WIDTH; result_hi is forced to 0 for non-MUL ops.
- States:
  - IDLE: busy=0, done=0.
  - start=1 with a non-MUL op: result/c_out/result_hi written at that edge → DONE.
  - start=1 with MUL: latch a into mcand, b into lo, clear hi/carry/counter → MUL.
  - MUL: busy=1. Each edge: if lo[0], {carry,hi} = hi + mcand; then {carry,hi,lo} >>= 1; counter++. On the edge where counter reaches WIDTH, write result=lo, result_hi=hi, c_out → DONE.
  - DONE: done=1 for exactly this cycle. start=1 is handled exactly as in IDLE (back-to-back); otherwise → IDLE.
- start while in MUL is ignored; a/b/alu_op changes during MUL have no effect.
- result/result_hi/c_out hold their value until the next completion or reset.
- Reset (any state, including mid-MUL): state IDLE, busy=0, done=0, c_out=0, result=0, result_hi=0, counter=0. Partial product discarded.

## Timing
- Non-MUL latency: start sampled at edge k → outputs valid and done=1 in cycle after edge k.
- MUL latency: start at edge k → busy=1 after k; final iteration at edge k+WIDTH → done=1, busy=0 in cycle after k+WIDTH. WIDTH=32 gives 32 cycles.
- Throughput: one non-MUL op per cycle when start is held high with new operands (IDLE→DONE→DONE…).
- busy and done are never high together; done never lasts more than one cycle per completed op.
- reset has priority over start in the same cycle.

## Test plan
- NOR, WIDTH=32: a=0x00000014, b=0x00000013 → result=0xFFFFFFE8, c_out=0, done one cycle. Then a=0x00000A40, b=0x00000F13 → 0xFFFFF0AC. Then OR on the same operands → 0x00000F53.
- ADD 0xFFFFFFFF+0x00000001 → result=0, c_out=1. SUB 3−5 → 0xFFFFFFFE, c_out=0. SLT a=0x80000000, b=1 → result=1.
- MUL 0xFFFFFFFF×0xFFFFFFFF → busy for 32 cycles, then result=0x00000001, result_hi=0xFFFFFFFE, c_out=1, done pulse exactly 32 edges after start. MUL 6×7 → result=42, result_hi=0, c_out=0.
- Start pulses and operand changes during MUL → ignored, final product unchanged. Back-to-back start with ADD in the DONE cycle → accepted, done high next cycle with the new sum.
- Reset asserted at MUL iteration 10 → next cycle busy=0, done=0, result=result_hi=0, c_out=0. A fresh MUL 6×7 afterwards completes correctly.
- WIDTH=8 instance: MUL 0xFF×0xFF → result=0x01, result_hi=0xFE after 8 cycles. ADD 0x80+0x80 → 0x00, c_out=1.
